rx_deinterleaver_wifi: RTL and testbench

RX_DEINTERLEAVER_WIFI -- requirements
Module: rx_deinterleaver_wifi

---
 rtl/rx_deinterleaver_wifi_pkg.sv | 17 +
 rtl/deint_addr_gen_wifi.sv | 46 ++++
 rtl/rx_deinterleaver_wifi.sv | 138 +++++++++++++
 tb/tb_rx_deinterleaver_wifi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_deinterleaver_wifi_pkg.sv
// Shared constants for the wifi BPSK (de)interleaver pair.
// Bank geometry and reader state encoding.
package rx_deinterleaver_wifi_pkg;

  localparam int N_CBPS = 48;
  localparam int N_COL  = 16;
  localparam int N_ROW  = 3;
  localparam int AW     = 6;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_CBPS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/deint_addr_gen_wifi.sv
// Write address generator: k = 16*(j mod 3) + j/3 from
// a mod-3 and a div-3 counter, plus a block-complete strobe.
module deint_addr_gen_wifi
  import rx_deinterleaver_wifi_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          block_done
);

  logic [1:0] mod_cnt;
  logic [3:0] div_cnt;
  logic [AW-1:0] base;

  // Row base selected by j mod 3; no multiplier needed.
  always_comb begin
    base = '0;
    unique case (1'b1)
      (mod_cnt == 2'd1): base = AW'(N_COL);
      (mod_cnt == 2'd2): base = AW'(N_COL + N_COL);
      default:           base = '0;
    endcase
    addr       = base + {2'b00, div_cnt};
    block_done = step && (mod_cnt == 2'd2)
                 && (div_cnt == 4'(N_COL - 1));
  end

  // Counters advance per accepted bit; div wraps 15->0 at block end.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mod_cnt <= '0;
      div_cnt <= '0;
    end else if (step) begin
      if (mod_cnt == 2'(N_ROW - 1)) begin
        mod_cnt <= '0;
        div_cnt <= div_cnt + 4'd1;
      end else begin
        mod_cnt <= mod_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/rx_deinterleaver_wifi.sv
// Wifi RX block deinterleaver, BPSK, ping-pong 48-bit banks.
// Scattered writes, sequential registered reads.
module rx_deinterleaver_wifi
  import rx_deinterleaver_wifi_pkg::*;
#(
  parameter int N_CBPS = rx_deinterleaver_wifi_pkg::N_CBPS
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic valid_in,
  input  logic data_in,
  output logic valid_out,
  output logic data_out,
  output logic finished
);

  logic [N_CBPS-1:0] bank [2];
  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;
  rd_state_t     state;

  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          blk_done;

  rd_state_t     state_n;
  logic          rd_sel_n;
  logic [AW-1:0] rd_addr_n;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_idx;
  logic          rd_last;
  logic          clr_full;

  assign clr   = reset || !enable;
  assign wr_en = enable && valid_in && !full[wr_sel];

  deint_addr_gen_wifi u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (!enable),
    .step       (wr_en),
    .addr       (wr_addr),
    .block_done (blk_done)
  );

  // Bank storage; stale data is masked by the full flags.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank[wr_sel][wr_addr] <= data_in;
    end
  end

  // Writer bank select and full flags.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_sel <= 1'b0;
      full   <= '0;
    end else begin
      if (clr_full) full[rd_sel] <= 1'b0;
      if (blk_done) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= !wr_sel;
      end
    end
  end

  // Reader next state: IDLE emits addr 0 at once to hit latency.
  always_comb begin
    state_n   = state;
    rd_sel_n  = rd_sel;
    rd_addr_n = rd_addr;
    rd_en     = 1'b0;
    rd_bank   = rd_sel;
    rd_idx    = rd_addr;
    clr_full  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|full) begin
          rd_bank   = (&full) ? wr_sel : full[1];
          rd_idx    = '0;
          rd_en     = 1'b1;
          rd_sel_n  = rd_bank;
          rd_addr_n = AW'(1);
          state_n   = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_addr == LAST_ADDR) begin
          clr_full  = 1'b1;
          rd_addr_n = '0;
          if (full[!rd_sel]) begin
            rd_sel_n = !rd_sel;
            state_n  = READ;
          end else begin
            state_n  = IDLE;
          end
        end else begin
          rd_addr_n = rd_addr + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    rd_last = rd_en && (rd_idx == LAST_ADDR);
  end

  // Reader state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      rd_sel  <= 1'b0;
      rd_addr <= '0;
    end else begin
      state   <= state_n;
      rd_sel  <= rd_sel_n;
      rd_addr <= rd_addr_n;
    end
  end

  // Registered output; data forced low when not valid.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      finished  <= 1'b0;
    end else begin
      valid_out <= rd_en;
      data_out  <= rd_en && bank[rd_bank][rd_idx];
      finished  <= rd_last;
    end
  end

endmodule

// File: tb/tb_rx_deinterleaver_wifi.sv
// Directed bench for rx_deinterleaver_wifi.
// Logs every cycle, then checks blocks against a k(j) model.
module tb_rx_deinterleaver_wifi;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic valid_in;
  logic data_in;
  logic valid_out;
  logic data_out;
  logic finished;

  int total = 0;
  int bad   = 0;

  logic vlog [$];
  logic dlog [$];
  logic flog [$];
  logic exp_q [$];
  logic out_q [$];

  int nvalid, first_v, bursts, nfin, fin_bad, viol, mism;
  logic [47:0] blk;
  logic [47:0] ov;
  logic [63:0] r;

  rx_deinterleaver_wifi #(.N_CBPS(48)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .finished  (finished)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs,
                     input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic v, input logic d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    vlog.push_back(valid_out);
    dlog.push_back(data_out);
    flog.push_back(finished);
    if (!valid_out && data_out) viol++;
    if (finished && !valid_out) viol++;
  endtask

  task automatic clear_logs();
    vlog.delete();
    dlog.delete();
    flog.delete();
    exp_q.delete();
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic model_push(input logic [47:0] b);
    logic [47:0] e;
    e = '0;
    for (int j = 0; j < 48; j++) e[16*(j%3) + j/3] = b[j];
    for (int k = 0; k < 48; k++) exp_q.push_back(e[k]);
  endtask

  // gap >= 0: fixed idle cycles after each bit; gap < 0: random 0..3
  task automatic send_block(input logic [47:0] b, input int gap);
    int g;
    model_push(b);
    for (int j = 0; j < 48; j++) begin
      tick(1'b1, b[j]);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int i = 0; i < g; i++) tick(1'b0, 1'b0);
    end
  endtask

  task automatic rand_block();
    r   = {$urandom(), $urandom()};
    blk = r[47:0];
  endtask

  task automatic scan();
    logic prev;
    nvalid = 0; first_v = -1; bursts = 0;
    nfin = 0; fin_bad = 0; prev = 1'b0;
    out_q.delete();
    for (int i = 0; i < vlog.size(); i++) begin
      if (vlog[i]) begin
        if (!prev) bursts++;
        if (first_v < 0) first_v = i;
        out_q.push_back(dlog[i]);
        nvalid++;
      end
      if (flog[i]) begin
        nfin++;
        if (!vlog[i] || (nvalid % 48) != 0) fin_bad++;
      end
      prev = vlog[i];
    end
    mism = 0;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) mism++;
    mism += (out_q.size() > exp_q.size())
            ? out_q.size() - exp_q.size()
            : exp_q.size() - out_q.size();
    ov = '0;
    for (int i = 0; i < 48 && i < out_q.size(); i++) ov[i] = out_q[i];
  endtask

  initial begin
    viol     = 0;
    reset    = 1'b1;
    enable   = 1'b1;
    valid_in = 1'b0;
    data_in  = 1'b0;

    // reset state
    flush(3);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_fin", finished, 0);
    reset = 1'b0;
    flush(5);
    chk("idle_valid", valid_out, 0);

    // single-one probe at j=1
    clear_logs();
    send_block(48'd1 << 1, 0);
    flush(60);
    scan();
    chk("probe_first", first_v, 48);
    chk("probe_count", nvalid, 48);
    chk("probe_bits", ov, 48'd1 << 16);
    chk("probe_fin", nfin, 1);
    chk("probe_fin_pos", fin_bad, 0);

    // index mapping: j=3->1, j=47->47, j=0->0, j=2->32
    clear_logs(); send_block(48'd1 << 3, 0); flush(60); scan();
    chk("map_j3", ov, 48'd1 << 1);
    clear_logs(); send_block(48'd1 << 47, 0); flush(60); scan();
    chk("map_j47", ov, 48'd1 << 47);
    clear_logs(); send_block(48'd1, 0); flush(60); scan();
    chk("map_j0", ov, 48'd1);
    clear_logs(); send_block(48'd1 << 2, 0); flush(60); scan();
    chk("map_j2", ov, 48'd1 << 32);

    // streaming: 4 back-to-back random blocks
    clear_logs();
    for (int b = 0; b < 4; b++) begin
      rand_block();
      send_block(blk, 0);
    end
    flush(60);
    scan();
    chk("stream_count", nvalid, 192);
    chk("stream_bursts", bursts, 1);
    chk("stream_fin", nfin, 4);
    chk("stream_fin_pos", fin_bad, 0);
    chk("stream_data", mism, 0);

    // 96 further random blocks with random gaps
    clear_logs();
    for (int b = 0; b < 96; b++) begin
      rand_block();
      send_block(blk, -1);
    end
    flush(60);
    scan();
    chk("rand_count", nvalid, 96 * 48);
    chk("rand_data", mism, 0);
    chk("rand_fin", nfin, 96);

    // gapped input, 1 bit every 3 cycles
    clear_logs();
    for (int b = 0; b < 2; b++) begin
      rand_block();
      send_block(blk, 2);
    end
    flush(60);
    scan();
    chk("gap_count", nvalid, 96);
    chk("gap_bursts", bursts, 2);
    chk("gap_fin_pos", fin_bad, 0);
    chk("gap_data", mism, 0);

    // enable drop after 20 bits
    clear_logs();
    for (int j = 0; j < 20; j++) tick(1'b1, 1'b1);
    enable = 1'b0;
    tick(1'b0, 1'b0);
    enable = 1'b1;
    flush(60);
    scan();
    chk("en_abort_none", nvalid, 0);
    clear_logs();
    rand_block();
    send_block(blk, 0);
    flush(60);
    scan();
    chk("en_abort_next", mism, 0);

    // reset after 20 bits
    clear_logs();
    for (int j = 0; j < 20; j++) tick(1'b1, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    flush(60);
    scan();
    chk("rst_abort_none", nvalid, 0);
    clear_logs();
    send_block(48'h0000_0000_0000, 0);
    flush(60);
    scan();
    chk("rst_abort_next", mism, 0);

    // full unread bank discarded by enable drop
    clear_logs();
    send_block(48'hFFFF_FFFF_FFFF, 0);
    enable = 1'b0;
    tick(1'b0, 1'b0);
    enable = 1'b1;
    flush(60);
    scan();
    chk("unread_discard", nvalid, 0);

    // enable drop mid-read stops output on next edge
    clear_logs();
    send_block(48'hFFFF_FFFF_FFFF, 0);
    flush(10);
    enable = 1'b0;
    tick(1'b0, 1'b0);
    chk("midread_valid", valid_out, 0);
    chk("midread_fin", finished, 0);
    enable = 1'b1;
    flush(60);
    scan();
    chk("midread_count", nvalid, 10);

    chk("output_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
